// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the mem_arbiter block.
// Holds the memory write-type codes, the arbiter FSM state type and the
// requester port indices, plus a helper that folds reserved write codes.
package mem_pkg;

    // Memory write-type encoding carried on d_we / m_we
    localparam logic [1:0] MW_NONE  = 2'b00;  // read
    localparam logic [1:0] MW_WORD  = 2'b01;  // write low 32 bits
    localparam logic [1:0] MW_DWORD = 2'b10;  // write all 64 bits

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Requester indices used for the grant and round-robin pointer
    localparam logic PORT_I = 1'b0;  // instruction fetch
    localparam logic PORT_D = 1'b1;  // data

    // The reserved code 2'b11 behaves as a read, so it is folded to MW_NONE
    // before it ever reaches the memory port.
    function automatic logic [1:0] mw_norm(input logic [1:0] we);
        return ((we == MW_WORD) || (we == MW_DWORD)) ? we : MW_NONE;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter (instruction fetch + data) in front of
// a single fixed-latency memory port.
//
// Sequence per access: IDLE (grant + latch operands) -> ACCESS for MEM_LAT
// cycles -> DONE (one-cycle ack) -> IDLE.
//
// Configuration macro: ARB_RR_EN
//   defined   : simultaneous requests alternate (round-robin)
//   undefined : data port always wins simultaneous requests
//
// MEM_LAT must be in 1..15 (the access counter is 4 bits wide).
module mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    // instruction-fetch requester (read-only)
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [63:0]       i_rdata,
    output logic              i_ack,
    // data requester
    input  logic              d_req,
    input  logic [1:0]        d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [63:0]       d_wdata,
    output logic [63:0]       d_rdata,
    output logic              d_ack,
    // shared memory port
    output logic [ADDR_W-1:0] m_addr,
    output logic [1:0]        m_we,
    output logic [63:0]       m_wdata,
    input  logic [63:0]       m_rdata,
    // status
    output logic              busy
);
    import mem_pkg::*;

    // Counter load value: ACCESS spans MEM_LAT cycles, counting down to 0
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_grant;
    logic [1:0]        r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [63:0]       r_wdata;
    logic [63:0]       r_i_rdata;
    logic [63:0]       r_d_rdata;
`ifdef ARB_RR_EN
    logic              r_rr_ptr;   // port that wins the next tie
`endif

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t            w_state_nxt;
    logic              w_any_req;
    logic              w_grant_sel;
    logic              w_first;
    logic              w_last;
    logic [1:0]        w_m_we;
    logic              w_busy;
    logic              w_i_ack;
    logic              w_d_ack;

    assign w_any_req = i_req | d_req;
    assign w_first   = (r_state == ST_ACCESS) && (r_cnt == LAT_M1);
    assign w_last    = (r_state == ST_ACCESS) && (r_cnt == 4'd0);

    // Choose which requester is granted if the FSM grants this cycle
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        w_grant_sel = PORT_D;
        if (i_req && d_req) begin
`ifdef ARB_RR_EN
            w_grant_sel = r_rr_ptr;
`else
            w_grant_sel = PORT_D;
`endif
        end else if (i_req) begin
            w_grant_sel = PORT_I;
        end
    end

    // Next-state and output decode for the access sequencer
    always_comb begin
        w_state_nxt = r_state;
        w_m_we      = MW_NONE;
        w_busy      = 1'b1;
        w_i_ack     = 1'b0;
        w_d_ack     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (w_any_req) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // write strobe only on the first ACCESS cycle
                if (w_first) begin
                    w_m_we = r_we;
                end
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_i_ack     = (r_grant == PORT_I);
                w_d_ack     = (r_grant == PORT_D);
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any access in flight without an ack
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Access-length down-counter: loaded on grant, decremented through ACCESS
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 4'd0;
        end else if ((r_state == ST_IDLE) && w_any_req) begin
            r_cnt <= LAT_M1;
        end else if ((r_state == ST_ACCESS) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Latch the granted requester's operands; they drive the memory port
    // unchanged until the next grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant <= PORT_D;
            r_we    <= MW_NONE;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if ((r_state == ST_IDLE) && w_any_req) begin
            r_grant <= w_grant_sel;
            if (w_grant_sel == PORT_D) begin
                r_we    <= mw_norm(d_we);
                r_addr  <= d_addr;
                r_wdata <= d_wdata;
            end else begin
                // fetches are reads; write data is left as it was
                r_we    <= MW_NONE;
                r_addr  <= i_addr;
            end
        end
    end

    // Capture read data into the granted port's register on the last
    // ACCESS cycle; writes leave both read-data registers untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else if (w_last && (r_we == MW_NONE)) begin
            if (r_grant == PORT_I) begin
                r_i_rdata <= m_rdata;
            end else begin
                r_d_rdata <= m_rdata;
            end
        end
    end

`ifdef ARB_RR_EN
    // Round-robin pointer: after any grant the other port gets priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= PORT_D;
        end else if ((r_state == ST_IDLE) && w_any_req) begin
            r_rr_ptr <= ~w_grant_sel;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;
    assign m_we    = w_m_we;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign i_ack   = w_i_ack;
    assign d_ack   = w_d_ack;
    assign busy    = w_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
// (default build, MEM_LAT = 2). Inputs change and outputs are sampled on the
// falling clock edge; the memory model updates on the rising edge.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int ADDR_W  = 8;
    localparam int MEM_LAT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [63:0]       i_rdata;
    logic              i_ack;
    logic              d_req;
    logic [1:0]        d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [63:0]       d_wdata;
    logic [63:0]       d_rdata;
    logic              d_ack;
    logic [ADDR_W-1:0] m_addr;
    logic [1:0]        m_we;
    logic [63:0]       m_wdata;
    logic [63:0]       m_rdata;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    // memory model with a preload port
    logic [63:0]       mem [256];
    logic              ld_en;
    logic [7:0]        ld_addr;
    logic [63:0]       ld_data;

    localparam logic [63:0] V20 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] V40 = 64'hCAFE_F00D_0000_0040;
    localparam logic [63:0] V48 = 64'hDEAD_BEEF_0000_0048;

    mem_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ack   (i_ack),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ack   (d_ack),
        .m_addr  (m_addr),
        .m_we    (m_we),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    assign m_rdata = mem[m_addr];

    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] = ld_data;
        end else if (m_we == MW_WORD) begin
            mem[m_addr][31:0] = m_wdata[31:0];
        end else if (m_we == MW_DWORD) begin
            mem[m_addr] = m_wdata;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] addr, input logic [63:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    // One data access from IDLE; caller is at a falling edge (cycle 0).
    task automatic data_access(input string tag, input logic [1:0] we,
                               input logic [7:0] addr, input logic [63:0] wdata,
                               input logic [1:0] exp_mwe, input logic [63:0] exp_rdata);
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        @(negedge clk);  // cycle 1: first ACCESS
        check({tag, " m_we first"}, 64'(m_we), 64'(exp_mwe));
        check({tag, " m_addr"}, 64'(m_addr), 64'(addr));
        check({tag, " busy"}, 64'(busy), 64'd1);
        if (exp_mwe != MW_NONE) begin
            check({tag, " m_wdata"}, m_wdata, wdata);
        end
        @(negedge clk);  // cycle 2: second ACCESS
        check({tag, " m_we second"}, 64'(m_we), 64'(MW_NONE));
        check({tag, " d_ack early"}, 64'(d_ack), 64'd0);
        @(negedge clk);  // cycle 3: DONE
        check({tag, " d_ack"}, 64'(d_ack), 64'd1);
        check({tag, " i_ack"}, 64'(i_ack), 64'd0);
        check({tag, " d_rdata"}, d_rdata, exp_rdata);
        d_req = 1'b0;
        @(negedge clk);  // cycle 4: IDLE
        check({tag, " d_ack off"}, 64'(d_ack), 64'd0);
        check({tag, " busy off"}, 64'(busy), 64'd0);
        check({tag, " m_addr held"}, 64'(m_addr), 64'(addr));
    endtask

    initial begin
        reset = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = MW_NONE; d_addr = '0; d_wdata = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        #12;
        // ---- reset state
        check("rst busy",    64'(busy),    64'd0);
        check("rst m_we",    64'(m_we),    64'd0);
        check("rst m_addr",  64'(m_addr),  64'd0);
        check("rst m_wdata", m_wdata,      64'd0);
        check("rst i_rdata", i_rdata,      64'd0);
        check("rst d_rdata", d_rdata,      64'd0);
        check("rst i_ack",   64'(i_ack),   64'd0);
        check("rst d_ack",   64'(d_ack),   64'd0);
        @(negedge clk);
        load(8'd84,  64'd0);
        load(8'h20,  V20);
        load(8'h40,  V40);
        load(8'h48,  V48);
        reset = 1'b0;

        // ---- word write, then read back; reserved code reads
        data_access("wr84", MW_WORD, 8'd84, 64'd7, MW_WORD, 64'd0);
        data_access("rd84", MW_NONE, 8'd84, 64'd0, MW_NONE, 64'd7);
        check("rd84 i_rdata", i_rdata, 64'd0);
        data_access("rd20r", 2'b11, 8'h20, 64'hFFFF, MW_NONE, V20);
        data_access("dw30", MW_DWORD, 8'h30, 64'hA5A5_A5A5_1111_2222, MW_DWORD, V20);
        data_access("ww30", MW_WORD, 8'h30, 64'hFFFF_FFFF_3333_4444, MW_WORD, V20);

        // ---- simultaneous requests: data first, fetch 4 cycles later
        i_req = 1'b1; i_addr = 8'h40;
        d_req = 1'b1; d_we = MW_NONE; d_addr = 8'h30;
        @(negedge clk);
        check("tie first grant", 64'(m_addr), 64'h30);
        @(negedge clk);
        @(negedge clk);
        check("tie d_ack", 64'(d_ack), 64'd1);
        check("tie i_ack0", 64'(i_ack), 64'd0);
        check("tie d_rdata", d_rdata, 64'hA5A5_A5A5_3333_4444);
        d_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("tie second grant", 64'(m_addr), 64'h40);
        @(negedge clk);
        @(negedge clk);
        check("tie i_ack", 64'(i_ack), 64'd1);
        check("tie d_ack1", 64'(d_ack), 64'd0);
        check("tie i_rdata", i_rdata, V40);
        i_req = 1'b0;
        @(negedge clk);

        // ---- reset during second ACCESS cycle of a fetch
        i_req = 1'b1; i_addr = 8'h48;
        @(negedge clk);  // ACCESS 1
        @(negedge clk);  // ACCESS 2
        reset = 1'b1;
        #1;
        check("abort busy",   64'(busy),   64'd0);
        check("abort i_ack",  64'(i_ack),  64'd0);
        check("abort m_addr", 64'(m_addr), 64'd0);
        check("abort i_rdata", i_rdata,    64'd0);
        @(negedge clk);
        check("abort i_ack hold", 64'(i_ack), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("reissue m_addr", 64'(m_addr), 64'h48);
        @(negedge clk);
        check("reissue i_ack early", 64'(i_ack), 64'd0);
        @(negedge clk);
        check("reissue i_ack", 64'(i_ack), 64'd1);
        check("reissue i_rdata", i_rdata, V48);
        i_req = 1'b0;
        @(negedge clk);
        check("reissue idle", 64'(busy), 64'd0);

        // ---- continuous fetch with one data write pulsed in
        i_req = 1'b1; i_addr = 8'h40;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            check($sformatf("stream m_we c%0d", c), 64'(m_we),
                  (c == 5) ? 64'(MW_WORD) : 64'(MW_NONE));
            check($sformatf("stream i_ack c%0d", c), 64'(i_ack),
                  (c == 3 || c == 11 || c == 15) ? 64'd1 : 64'd0);
            check($sformatf("stream d_ack c%0d", c), 64'(d_ack),
                  (c == 7) ? 64'd1 : 64'd0);
            if (c == 5) begin
                check("stream wr addr", 64'(m_addr), 64'h50);
                check("stream wr data", m_wdata, 64'h0000_0000_0000_BEEF);
            end
            if (c == 4) begin
                d_req = 1'b1; d_we = MW_WORD; d_addr = 8'h50; d_wdata = 64'hBEEF;
            end
            if (c == 7) begin
                d_req = 1'b0;
            end
            if (c == 16) begin
                check("stream idle", 64'(busy), 64'd0);
                i_req = 1'b0;
            end
        end
        check("stream i_rdata", i_rdata, V40);
        check("stream mem50", 64'(mem[8'h50][31:0]), 64'hBEEF);
        @(negedge clk);
        check("end busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, byte address width.
REQ-002 The block SHALL have parameter MEM_LAT, default 2, memory access latency in cycles (legal 1..15).
REQ-003 The block SHALL have port clk  input  1  single clock, rising-edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have ports i_req in 1, i_addr in ADDR_W, i_rdata out 64, i_ack out 1: the instruction-fetch requester (read-only).
REQ-006 The block SHALL have ports d_req in 1, d_we in 2 (00 read, 01 write 32-bit word, 10 write 64-bit dword, 11 reserved=read), d_addr in ADDR_W, d_wdata in 64, d_rdata out 64, d_ack out 1: the data requester.
REQ-007 The block SHALL have ports m_addr out ADDR_W, m_we out 2, m_wdata out 64, m_rdata in 64: the single shared memory port.
REQ-008 The block SHALL have port busy  output  1, high when not IDLE.

Function
REQ-009 The FSM SHALL have states IDLE, ACCESS, DONE.
REQ-010 In IDLE with any req high, the arbiter SHALL grant one port, latch its address/we/wdata and the grant, and enter ACCESS on the next edge.
REQ-011 In IDLE with both reqs high, grant SHALL follow the policy of REQ-022/023.
REQ-012 ACCESS SHALL last exactly MEM_LAT cycles, counted by a down-counter loaded with MEM_LAT-1.
REQ-013 m_addr and m_wdata SHALL be held stable for all ACCESS cycles; m_we SHALL equal the latched we only in the first ACCESS cycle and 00 otherwise.
REQ-014 m_rdata SHALL be captured into the granted port's rdata register on the last ACCESS cycle; for writes, rdata SHALL be left unchanged.
REQ-015 DONE SHALL last one cycle, pulse exactly the granted port's ack, then return to IDLE.
REQ-016 Requests SHALL be ignored in ACCESS and DONE; a requester SHALL hold req and operands until its ack and drop req the cycle after ack, otherwise a repeat access is issued.
REQ-017 Idle latency from req sampled to ack SHALL be MEM_LAT+1 cycles; sustained throughput SHALL be one access per MEM_LAT+2 cycles.
REQ-018 i_rdata and d_rdata SHALL hold their last captured value until their next read completes.
REQ-019 Outside ACCESS, m_we SHALL be 00 and m_addr SHALL hold its last value.

Reset
REQ-020 On reset: state IDLE, counter 0, m_we 00, m_addr 0, m_wdata 0, i_rdata 0, d_rdata 0, i_ack 0, d_ack 0, busy 0, round-robin pointer to data port.
REQ-021 Reset asserted mid-access SHALL abort immediately; no ack SHALL be issued for the aborted access.

Configuration
REQ-022 With ARB_RR_EN defined, simultaneous requests SHALL alternate: the port not granted last SHALL win; the pointer updates only on grant.
REQ-023 Without ARB_RR_EN, the data port SHALL always win simultaneous requests (fixed priority).

Structure
REQ-024 A shared package mem_pkg SHALL hold the memwrite encoding constants (MW_NONE, MW_WORD, MW_DWORD), the FSM state enum, and the port-index constants.
REQ-025 No sub-module; a single RTL module of 120-400 lines.

Verification (MEM_LAT=2)
REQ-026 d_req, d_we=01, d_addr=84, d_wdata=7 at cycle 0 -> m_we=01, m_addr=84, m_wdata=7 at cycle 1 only; d_ack at cycle 3.
REQ-027 Data read of address 84 after REQ-026, with the memory model returning 7 -> d_rdata=7 at d_ack; i_rdata unchanged.
REQ-028 i_req and d_req raised in the same cycle, both held -> fixed build: data ack then fetch ack 4 cycles later; ARB_RR_EN build: acks alternate over 4 accesses.
REQ-029 Reset pulsed during the second ACCESS cycle of a fetch -> busy=0 and no i_ack; reissued fetch completes in 3 cycles.
REQ-030 Continuous i_req with d_req pulsed -> no m_we except in the data write's first ACCESS cycle; one ack per 4 cycles.
